// File: rtl/s2p.sv
// s2p: serial-to-parallel receiver, MSB-first framing with sync marker,
// completed words buffered in a first-word-fall-through FIFO.
module s2p #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         ser_in,
    input  logic                         ser_sync,
    output logic [WIDTH-1:0]             dout,
    output logic                         dout_valid,
    input  logic                         dout_ready,
    output logic                         frame_err,
    output logic                         overflow,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int CW = $clog2(WIDTH);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = $clog2(DEPTH + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             ferr_q, ferr_d;
    logic             ovf_q, ovf_d;
    logic [PW-1:0]    wr_q, rd_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [WIDTH-1:0] word;
    logic             push, pop, full, empty, wr_en;

    assign word = {shreg_q[WIDTH-2:0], ser_in};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        ferr_d  = 1'b0;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ser_sync) begin
                    shreg_d = {{(WIDTH-1){1'b0}}, ser_in};
                    cnt_d   = CW'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (ser_sync) begin
                    // A sync mid-frame restarts framing on this bit
                    ferr_d  = 1'b1;
                    shreg_d = {{(WIDTH-1){1'b0}}, ser_in};
                    cnt_d   = CW'(1);
                end else if (cnt_q == CW'(WIDTH - 1)) begin
                    push    = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    shreg_d = word;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            ferr_q  <= ferr_d;
        end
    end

    // Full vs empty is told apart by the extra pointer MSB
    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW])
                && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop   = !empty && dout_ready;
    assign wr_en = push && (!full || pop);
    assign ovf_d = push && full && !pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            ovf_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ovf_q <= ovf_d;
            if (wr_en) begin
                mem_q[wr_q[AW-1:0]] <= word;
                wr_q                <= wr_q + PW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + PW'(1);
            end
        end
    end

    assign dout       = mem_q[rd_q[AW-1:0]];
    assign dout_valid = !empty;
    assign frame_err  = ferr_q;
    assign overflow   = ovf_q;
    assign busy       = (state_q == SHIFT);
    assign level      = LW'(wr_q - rd_q);

endmodule

// File: tb/tb_s2p.sv
// tb_s2p: table vectors, directed corner sequences and random stimulus
// checked against a queue-based frame/FIFO reference model.
module tb_s2p;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         ser_in = 1'b0;
    logic         ser_sync = 1'b0;
    logic         dout_ready = 1'b0;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         frame_err;
    logic         overflow;
    logic         busy;
    logic [2:0]   level;

    always #5 clk = ~clk;

    s2p #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ser_in     (ser_in),
        .ser_sync   (ser_sync),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .busy       (busy),
        .level      (level)
    );

    int nvec = 0;
    int nerr = 0;
    int cycn = 0;

    int mq[$];
    bit mframe;
    int mval, mn;
    bit mferr, movf;

    int log_q[$];
    int log_t[$];
    int ferr_cnt, ovf_cnt;

    typedef struct {
        bit       s;
        bit       b;
        bit       r;
        bit       ev;
        logic [7:0] ed;
        bit       eb;
        int       el;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cycn);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mframe = 0;
        mval = 0;
        mn = 0;
        mferr = 0;
        movf = 0;
    endtask

    // One clock: drive inputs, advance the model, compare all outputs
    task automatic cyc(input bit s, input bit b, input bit r);
        bit mpop, done;
        ser_sync = s;
        ser_in = b;
        dout_ready = r;
        if (dout_valid && r) begin
            log_q.push_back(int'(dout));
            log_t.push_back(cycn);
        end
        mpop = (mq.size() > 0) && r;
        @(posedge clk);
        #1;
        cycn++;
        mferr = 0;
        movf = 0;
        done = 0;
        if (s) begin
            if (mframe) mferr = 1;
            mframe = 1;
            mval = int'(b);
            mn = 1;
        end else if (mframe) begin
            mval = mval * 2 + int'(b);
            mn++;
            if (mn == W) begin
                done = 1;
                mframe = 0;
            end
        end
        if (mpop) void'(mq.pop_front());
        if (done) begin
            if (mq.size() == D) movf = 1;
            else mq.push_back(mval);
        end
        chk("valid", dout_valid, mq.size() > 0);
        chk("level", level, mq.size());
        chk("busy", busy, mframe);
        chk("frame_err", frame_err, mferr);
        chk("overflow", overflow, movf);
        if (mq.size() > 0) chk("dout", dout, mq[0]);
        ferr_cnt += int'(frame_err);
        ovf_cnt += int'(overflow);
    endtask

    task automatic send(input int w, input bit r);
        for (int i = 0; i < W; i++) begin
            cyc(i == 0, w[W-1-i], r);
        end
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'($urandom % 2), r);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dout"}, dout, 0);
        chk({tag, "_valid"}, dout_valid, 0);
        chk({tag, "_ferr"}, frame_err, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_level"}, level, 0);
    endtask

    initial begin
        logic [7:0] a5;
        logic [7:0] w5;
        a5 = 8'hA5;
        w5 = 8'h05;
        for (int i = 0; i < 8; i++) begin
            tbl[i] = '{i == 0, a5[7-i], 1'b1, i == 7, 8'hA5, i < 7,
                       (i == 7) ? 1 : 0};
        end
        tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0};
        tbl[9] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 0};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("rst");
        #2;
        reset_n = 1'b1;

        // Single frame 0xA5
        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].s, tbl[i].b, tbl[i].r);
            chk("tbl_valid", dout_valid, tbl[i].ev);
            if (tbl[i].ev) chk("tbl_dout", dout, tbl[i].ed);
            chk("tbl_busy", busy, tbl[i].eb);
            chk("tbl_level", level, tbl[i].el);
        end

        // Back-to-back frames
        log_q.delete();
        log_t.delete();
        ferr_cnt = 0;
        send(32'h3C, 1'b1);
        send(32'hC3, 1'b1);
        idle(2, 1'b1);
        chk("b2b_count", log_q.size(), 2);
        if (log_q.size() >= 2) begin
            chk("b2b_w0", log_q[0], 32'h3C);
            chk("b2b_w1", log_q[1], 32'hC3);
            chk("b2b_gap", log_t[1] - log_t[0], 8);
        end
        chk("b2b_ferr", ferr_cnt, 0);

        // Mid-frame sync
        log_q.delete();
        ferr_cnt = 0;
        cyc(1'b1, 1'b1, 1'b1);
        repeat (3) cyc(1'b0, 1'b1, 1'b1);
        send(32'h12, 1'b1);
        idle(2, 1'b1);
        chk("mid_ferr", ferr_cnt, 1);
        chk("mid_count", log_q.size(), 1);
        if (log_q.size() >= 1) chk("mid_w0", log_q[0], 32'h12);

        // Backpressure and overflow
        ovf_cnt = 0;
        for (int k = 1; k <= 5; k++) send(k, 1'b0);
        chk("bp_level", level, 4);
        chk("bp_ovf", ovf_cnt, 1);
        log_q.delete();
        idle(6, 1'b1);
        chk("bp_count", log_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (log_q.size() > k) chk("bp_word", log_q[k], k + 1);
        end
        chk("bp_drained", level, 0);

        // Full FIFO, pop coincides with the completing word
        ovf_cnt = 0;
        for (int k = 1; k <= 4; k++) send(k, 1'b0);
        for (int i = 0; i < W; i++) cyc(i == 0, w5[W-1-i], i == W - 1);
        chk("fp_ovf", ovf_cnt, 0);
        chk("fp_level", level, 4);
        log_q.delete();
        idle(6, 1'b1);
        chk("fp_count", log_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (log_q.size() > k) chk("fp_word", log_q[k], k + 2);
        end

        // Reset mid-operation
        send(32'h11, 1'b0);
        send(32'h22, 1'b0);
        for (int i = 0; i < 4; i++) cyc(i == 0, 1'b1, 1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        chk_zero("amid");
        model_reset();
        log_q.delete();
        #3;
        reset_n = 1'b1;
        send(32'h5A, 1'b1);
        idle(3, 1'b1);
        chk("rst_count", log_q.size(), 1);
        if (log_q.size() >= 1) chk("rst_w0", log_q[0], 32'h5A);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 9) == 0, 1'($urandom % 2),
                1'($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 400; i++) begin
            if (i % 10 < 8) cyc(i % 10 == 0, 1'($urandom % 2), 1'($urandom % 2));
            else cyc(1'b0, 1'($urandom % 2), 1'($urandom % 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
